// File: rtl/gmii_word_pack_pkg.sv
// Shared definitions for the GMII byte/word packers.
// Comma constant and alignment state encoding.
package gmii_word_pack_pkg;

  localparam logic [7:0] K28_5 = 8'hBC;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } align_state_t;

endpackage

// File: rtl/gmii_word_pack.sv
// Packs 8-bit PCS bytes into 16-bit GTP TX words,
// keeping every comma in the low byte slot.
module gmii_word_pack
  import gmii_word_pack_pkg::*;
#(
  parameter logic [7:0] COMMA    = K28_5,
  parameter int         LOCK_CNT = 4,
  parameter int         SLIP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_k,
  input  logic              in_valid,
  output logic [15:0]       word_data,
  output logic [1:0]        word_k,
  output logic              word_stb,
  output logic              aligned,
  output logic [SLIP_W-1:0] slip_count
);

  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_CNT);
  localparam logic [LW-1:0] LOCK_PRE = LW'(LOCK_CNT - 1);

  logic         phase;
  logic [7:0]   pend_data;
  logic         pend_k;
  logic [LW-1:0] lock_cnt;
  align_state_t state;

  logic is_comma;
  logic slip;
  logic even_comma;
  logic lock_hit;

  assign is_comma   = in_valid & in_k & (in_data == COMMA);
  assign slip       = phase & is_comma;
  assign even_comma = ~phase & is_comma;
  assign lock_hit   = even_comma & (lock_cnt >= LOCK_PRE);
  assign aligned    = (state == LOCKED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= 1'b0;
      pend_data <= '0;
      pend_k    <= 1'b0;
      word_data <= '0;
      word_k    <= '0;
      word_stb  <= 1'b0;
    end else begin
      word_stb <= 1'b0;
      if (in_valid) begin
        unique case (1'b1)
          !phase: begin
            pend_data <= in_data;
            pend_k    <= in_k;
            phase     <= 1'b1;
          end
          slip: begin
            // Misaligned comma restarts the word; phase stays high.
            pend_data <= in_data;
            pend_k    <= in_k;
          end
          default: begin
            word_data <= {in_data, pend_data};
            word_k    <= {in_k, pend_k};
            word_stb  <= 1'b1;
            phase     <= 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (slip) begin
      lock_cnt <= '0;
    end else if (even_comma && lock_cnt != LOCK_MAX) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= HUNT;
      slip_count <= '0;
    end else if (slip) begin
      state <= HUNT;
      if (slip_count != '1)
        slip_count <= slip_count + 1'b1;
    end else if (lock_hit) begin
      state <= LOCKED;
    end
  end

endmodule

// File: tb/tb_gmii_word_pack.sv
// Randomized scoreboard bench for gmii_word_pack.
// Reference model works on a queue of held bytes.
module tb_gmii_word_pack;

  localparam logic [7:0] BC = 8'hBC;
  localparam int LOCKN = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_k = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] word_data;
  logic [1:0]  word_k;
  logic        word_stb;
  logic        aligned;
  logic [7:0]  slip_count;

  gmii_word_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_k       (in_k),
    .in_valid   (in_valid),
    .word_data  (word_data),
    .word_k     (word_k),
    .word_stb   (word_stb),
    .aligned    (aligned),
    .slip_count (slip_count)
  );

  always #4 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       k;
  } byte_t;

  exp_t  wq[$];
  byte_t held[$];
  int    m_lock = 0;
  int    m_slip = 0;
  bit    m_aligned = 1'b0;
  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  logic [15:0] last_wd = '0;
  logic [1:0]  last_wk = '0;

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)",
               n, act, exp, cyc);
    end
  endtask

  // Words are built from pairs of bytes; a comma may only
  // start a pair, otherwise the half-built pair is thrown away.
  function automatic void model_byte(input logic [7:0] d,
                                     input logic k);
    bit     comma;
    byte_t  b;
    byte_t  lo;
    exp_t   e;
    comma = k && (d == BC);
    b.d = d;
    b.k = k;
    if (held.size() == 0) begin
      held.push_back(b);
      if (comma) begin
        if (m_lock < LOCKN) m_lock++;
        if (m_lock == LOCKN) m_aligned = 1'b1;
      end
    end else if (comma) begin
      held.delete();
      held.push_back(b);
      if (m_slip < 255) m_slip++;
      m_lock = 0;
      m_aligned = 1'b0;
    end else begin
      lo = held.pop_front();
      e.d = {d, lo.d};
      e.k = {k, lo.k};
      e.cyc = cyc + 1;
      wq.push_back(e);
    end
  endfunction

  function automatic void model_reset();
    held.delete();
    wq.delete();
    m_lock = 0;
    m_slip = 0;
    m_aligned = 1'b0;
  endfunction

  task automatic send(input logic [7:0] d, input logic k);
    @(negedge clk);
    in_data  = d;
    in_k     = k;
    in_valid = 1'b1;
    model_byte(d, k);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 8'($urandom);
      in_k     = 1'($urandom);
    end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_data"}, 32'(word_data), 32'h0);
    chk({n, "_k"}, 32'(word_k), 32'h0);
    chk({n, "_stb"}, 32'(word_stb), 32'h0);
    chk({n, "_aligned"}, 32'(aligned), 32'h0);
    chk({n, "_slip"}, 32'(slip_count), 32'h0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #3;
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    #1;
    chk_zero("rst_async");
    repeat (2) @(negedge clk);
    chk_zero("rst_hold");
    rst = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    if (rst) begin
      last_wd = '0;
      last_wk = '0;
    end else begin
      chk("aligned", 32'(aligned), 32'(m_aligned));
      chk("slip_count", 32'(slip_count), 32'(m_slip));
      if (word_stb) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stb: got word %h expected none",
                   word_data);
        end else begin
          e = wq.pop_front();
          chk("word_data", 32'(word_data), 32'(e.d));
          chk("word_k", 32'(word_k), 32'(e.k));
          chk("latency", 32'(cyc), 32'(e.cyc));
          last_wd = e.d;
          last_wk = e.k;
        end
      end else begin
        chk("hold_data", 32'(word_data), 32'(last_wd));
        chk("hold_k", 32'(word_k), 32'(last_wk));
        if (wq.size() != 0 && wq[0].cyc < cyc) begin
          e = wq.pop_front();
          checks++;
          errors++;
          $display("FAIL missing_stb: got none expected word %h", e.d);
        end
      end
    end
  end

  initial begin
    int r;
    #1;
    rst = 1'b1;
    #1;
    chk_zero("rst_init");
    repeat (3) @(negedge clk);
    rst = 1'b0;

    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    idle(2);

    repeat (5) begin
      send(BC, 1'b1);
      send(8'h50, 1'b0);
    end
    idle(2);
    chk("locked", 32'(aligned), 32'h1);
    chk("no_slip", 32'(slip_count), 32'h0);

    send(8'h50, 1'b0);
    send(BC, 1'b1);
    send(8'h50, 1'b0);
    idle(2);
    chk("slip_one", 32'(slip_count), 32'h1);
    chk("unlocked", 32'(aligned), 32'h0);

    send(8'h11, 1'b0);
    idle(3);
    send(8'h22, 1'b0);
    idle(2);

    send(8'h00, 1'b0);
    repeat (300) send(BC, 1'b1);
    idle(2);
    chk("slip_sat", 32'(slip_count), 32'hFF);

    async_reset();
    send(8'h11, 1'b0);
    async_reset();
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    idle(2);
    chk("post_rst_word", 32'(word_data), 32'hBBAA);

    async_reset();
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 3)
        idle(int'($urandom_range(1, 3)));
      else if (r < 7)
        send(BC, 1'b1);
      else
        send(8'($urandom), 1'($urandom_range(0, 7) == 0));
    end
    idle(4);
    chk("drained", 32'(wq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
